text_console_ctrl: RTL

Character-terminal controller that owns the 80x60 text cell buffer feeding the character-mode VGA block. It accepts a stream of ASCII bytes plus colour over a valid/ready handshake and maintains the cursor. It interprets control codes (LF, CR, BS, FF), scrolls through a circular row offset, and clears rows or the whole screen with multi-cycle sequences. It also serves the VGA block's 13-bit cell address with 20-bit {rrrr_gggg_bbbb, ascii} data.

---
 rtl/console_pkg.sv | 21 ++
 rtl/text_ram.sv | 22 ++
 rtl/text_console_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants, control codes and FSM state type for the text console
package console_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 60;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [7:0]  CURSOR_GLYPH = 8'h5F;
    localparam logic [19:0] BLANK_CELL   = 20'h00020;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - 8192x20 cell buffer, synchronous write port, asynchronous read port
module text_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [12:0] waddr,
    input  logic [19:0] wdata,
    input  logic [12:0] raddr,
    output logic [19:0] rdata
);

    logic [19:0] mem [0:8191];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write contents on a same-cycle collision.
    assign rdata = mem[raddr];

endmodule

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - character terminal controller; CONSOLE_CURSOR_BLINK_EN adds a blinking cursor
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int          COLS         = COLS_DEFAULT,
    parameter int          ROWS         = ROWS_DEFAULT,
    parameter int          BLINK_CYCLES = 12500000,
    parameter logic [11:0] CURSOR_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [11:0] in_color,
    input  logic [12:0] vga_addr,
    output logic [19:0] vga_data,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

    if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 64 || BLINK_CYCLES < 1) begin : g_param_check
        $error("text_console_ctrl: parameter out of range");
    end

    function automatic logic [5:0] phys(input logic [5:0] y, input logic [5:0] top);
        logic [6:0] s;
        s = {1'b0, y} + {1'b0, top};
        if (s >= 7'(ROWS)) begin
            s = s - 7'(ROWS);
        end
        return s[5:0];
    endfunction

    state_t     state_q, state_d;
    logic [6:0] cursor_x_q, cursor_x_d;
    logic [5:0] cursor_y_q, cursor_y_d;
    logic [5:0] top_row_q, top_row_d;
    logic [6:0] clr_x_q, clr_x_d;
    logic [5:0] clr_y_q, clr_y_d;

    logic        we;
    logic [12:0] waddr;
    logic [19:0] wdata;
    logic [12:0] raddr;
    logic [19:0] rdata;

    logic       xfer, is_print, newline;
    logic [5:0] top_next;
    logic [6:0] bs_x;
    logic [5:0] bs_y;

    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;

    assign xfer     = in_valid && in_ready;
    assign is_print = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign newline  = (in_char == CH_LF) || (is_print && cursor_x_q == X_LAST);
    assign top_next = (top_row_q == Y_LAST) ? 6'd0 : top_row_q + 6'd1;

    // Backspace target; at the origin it stays put but still blanks the cell.
    always_comb begin
        bs_x = cursor_x_q;
        bs_y = cursor_y_q;
        if (cursor_x_q != 7'd0) begin
            bs_x = cursor_x_q - 7'd1;
        end else if (cursor_y_q != 6'd0) begin
            bs_x = X_LAST;
            bs_y = cursor_y_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLR_ALL;
            cursor_x_q <= 7'd0;
            cursor_y_q <= 6'd0;
            top_row_q  <= 6'd0;
            clr_x_q    <= 7'd0;
            clr_y_q    <= 6'd0;
        end else begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            top_row_q  <= top_row_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        top_row_d  = top_row_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (is_print || in_char == CH_LF) begin
                        cursor_x_d = cursor_x_q + 7'd1;
                        if (newline) begin
                            cursor_x_d = 7'd0;
                            if (cursor_y_q == Y_LAST) begin
                                top_row_d = top_next;
                                clr_x_d   = 7'd0;
                                state_d   = CLR_ROW;
                            end else begin
                                cursor_y_d = cursor_y_q + 6'd1;
                            end
                        end
                    end else begin
                        case (in_char)
                            CH_CR: cursor_x_d = 7'd0;
                            CH_BS: begin
                                cursor_x_d = bs_x;
                                cursor_y_d = bs_y;
                            end
                            CH_FF: begin
                                cursor_x_d = 7'd0;
                                cursor_y_d = 6'd0;
                                top_row_d  = 6'd0;
                                clr_x_d    = 7'd0;
                                clr_y_d    = 6'd0;
                                state_d    = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLR_ROW: begin
                clr_x_d = clr_x_q + 7'd1;
                if (clr_x_q == X_LAST) begin
                    clr_x_d = 7'd0;
                    state_d = IDLE;
                end
            end
            CLR_ALL: begin
                top_row_d = 6'd0;
                clr_x_d   = clr_x_q + 7'd1;
                if (clr_x_q == X_LAST) begin
                    clr_x_d = 7'd0;
                    clr_y_d = clr_y_q + 6'd1;
                    if (clr_y_q == Y_LAST) begin
                        clr_y_d = 6'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = CLR_ALL;
        endcase
    end

    // CLR_ROW blanks the new bottom line, which top_row_q already points past.
    always_comb begin
        we    = 1'b0;
        waddr = {cursor_x_q, phys(cursor_y_q, top_row_q)};
        wdata = BLANK_CELL;
        case (state_q)
            IDLE: begin
                if (xfer && is_print) begin
                    we    = 1'b1;
                    wdata = {in_color, in_char};
                end else if (xfer && in_char == CH_BS) begin
                    we    = 1'b1;
                    waddr = {bs_x, phys(bs_y, top_row_q)};
                end
            end
            CLR_ROW: begin
                we    = 1'b1;
                waddr = {clr_x_q, phys(Y_LAST, top_row_q)};
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = {clr_x_q, clr_y_q};
            end
            default: ;
        endcase
    end

    text_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    logic [6:0] vga_x;
    logic [5:0] vga_y;
    logic       in_range;
    logic       show_cursor;

    assign vga_x    = vga_addr[12:6];
    assign vga_y    = vga_addr[5:0];
    assign raddr    = {vga_x, phys(vga_y, top_row_q)};
    assign in_range = ({1'b0, vga_x} < 8'(COLS)) && ({1'b0, vga_y} < 7'(ROWS));

`ifdef CONSOLE_CURSOR_BLINK_EN
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 32'd0;
            blink_on_d  = ~blink_on_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= 32'd0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign show_cursor = blink_on_q && (state_q == IDLE) &&
                         (vga_x == cursor_x_q) && (vga_y == cursor_y_q);
`else
    assign show_cursor = 1'b0;
`endif

    always_comb begin
        vga_data = rdata;
        if (!in_range) begin
            vga_data = 20'h0;
        end else if (show_cursor) begin
            vga_data = {CURSOR_COLOR, CURSOR_GLYPH};
        end
    end

endmodule
